// File: rtl/vram_dbuf.sv
// N-segment double-buffered VRAM: the CPU edits the back banks, the PPU reads the front banks,
// and a swap at vblank is followed by a front-to-back copy so the CPU resumes on a coherent frame.
module vram_dbuf #(
    parameter  int NSEG   = 4,
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 2**ADDR_W,
    localparam int SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [SEG_W-1:0]         cpu_seg,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DATA_W-1:0]        cpu_rdata,
    input  logic                     swap_req,
    input  logic                     vblank_start,
    output logic                     swap_pending,
    output logic                     sync_busy,
    output logic                     swap_done,
    output logic                     front_sel,
    input  logic [NSEG*ADDR_W-1:0]   ppu_addr,
    output logic [NSEG*DATA_W-1:0]   ppu_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               req_latched;
    logic               cpu_acc;
    logic               cpu_in_range;
    logic               copy_we;
    logic [ADDR_W-1:0]  copy_raddr;
    logic [ADDR_W-1:0]  copy_waddr;
    logic [DATA_W-1:0]  rd_word [NSEG];

    always_comb begin
        cpu_acc      = cpu_req && cpu_ready;
        cpu_in_range = (32'(cpu_seg) < 32'(NSEG)) && (32'(cpu_addr) < 32'(DEPTH));
        // Copy write trails the copy read by one cycle, so it targets cnt-1.
        copy_we      = (state == COPY) && (cnt != '0);
        copy_raddr   = ADDR_W'(cnt);
        copy_waddr   = ADDR_W'(cnt - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            req_latched  <= 1'b0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            sync_busy    <= 1'b0;
            swap_done    <= 1'b0;
            cpu_ready    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b1;
                    if (swap_req) begin
                        state        <= PENDING;
                        swap_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    cpu_ready <= 1'b1;
                    if (vblank_start) begin
                        state        <= COPY;
                        front_sel    <= ~front_sel;
                        cnt          <= '0;
                        sync_busy    <= 1'b1;
                        swap_pending <= 1'b0;
                        cpu_ready    <= 1'b0;
                    end
                end
                COPY: begin
                    if (cnt == CNT_W'(DEPTH)) begin
                        state        <= (req_latched || swap_req) ? PENDING : IDLE;
                        swap_pending <= req_latched || swap_req;
                        req_latched  <= 1'b0;
                        sync_busy    <= 1'b0;
                        swap_done    <= 1'b1;
                        cpu_ready    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (swap_req)
                            req_latched <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        logic [DATA_W-1:0] mem [2][DEPTH];
        logic [DATA_W-1:0] copy_q;
        logic [DATA_W-1:0] ppu_q;
        logic [ADDR_W-1:0] pa;

        assign pa         = ppu_addr[g*ADDR_W +: ADDR_W];
        assign rd_word[g] = mem[~front_sel][cpu_addr];
        assign ppu_rdata[g*DATA_W +: DATA_W] = ppu_q;

        // Port B: CPU or copy writes go to the back bank, copy reads come from the front bank.
        always_ff @(posedge clk) begin
            if (copy_we)
                mem[~front_sel][copy_waddr] <= copy_q;
            else if (cpu_acc && cpu_we && cpu_in_range && cpu_seg == SEG_W'(g))
                mem[~front_sel][cpu_addr] <= cpu_wdata;
            copy_q <= mem[front_sel][copy_raddr];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ppu_q <= '0;
            else
                ppu_q <= mem[front_sel][pa];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_acc && !cpu_we;
            if (cpu_acc && !cpu_we)
                cpu_rdata <= cpu_in_range ? rd_word[cpu_seg] : '0;
        end
    end

endmodule

// File: tb/tb_vram_dbuf.sv
// Directed-plus-random bench for vram_dbuf against a bank-level reference model
// that treats a swap as an atomic flip followed by a whole-bank copy.
module tb_vram_dbuf;
    localparam int NSEG = 4, ADDR_W = 5, DATA_W = 16, DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cpu_req, cpu_we;
    logic [1:0]             cpu_seg;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic                   cpu_ready, cpu_rvalid;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   swap_req, vblank_start;
    logic                   swap_pending, sync_busy, swap_done, front_sel;
    logic [NSEG*ADDR_W-1:0] ppu_addr;
    logic [NSEG*DATA_W-1:0] ppu_rdata;

    vram_dbuf #(.NSEG(NSEG), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_seg(cpu_seg), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .swap_req(swap_req), .vblank_start(vblank_start),
        .swap_pending(swap_pending), .sync_busy(sync_busy), .swap_done(swap_done),
        .front_sel(front_sel), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] mm [2][NSEG][DEPTH];
    int mfront = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int seg, input int addr, input logic [DATA_W-1:0] d);
        chk("wr_ready", cpu_ready, 1);
        cpu_req = 1; cpu_we = 1; cpu_seg = 2'(seg); cpu_addr = ADDR_W'(addr); cpu_wdata = d;
        cycle();
        cpu_req = 0; cpu_we = 0;
        if (addr < DEPTH) mm[1-mfront][seg][addr] = d;
    endtask

    task automatic cpu_read(input int seg, input int addr);
        logic [DATA_W-1:0] exp;
        exp = (addr < DEPTH) ? mm[1-mfront][seg][addr] : '0;
        cpu_req = 1; cpu_we = 0; cpu_seg = 2'(seg); cpu_addr = ADDR_W'(addr);
        cycle();
        cpu_req = 0;
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_data", cpu_rdata, exp);
    endtask

    task automatic ppu_check(input bit rnd, input int addr);
        logic [63:0] exp;
        int a;
        exp = '0;
        for (int s = 0; s < NSEG; s++) begin
            a = rnd ? int'($urandom_range(0, DEPTH-1)) : addr;
            ppu_addr[s*ADDR_W +: ADDR_W] = ADDR_W'(a);
            exp[s*DATA_W +: DATA_W] = mm[mfront][s][a];
        end
        cycle();
        chk("ppu_rdata", ppu_rdata, exp);
    endtask

    task automatic verify_all();
        for (int s = 0; s < NSEG; s++)
            for (int a = 0; a < DEPTH; a++)
                cpu_read(s, a);
        for (int a = 0; a < DEPTH; a++)
            ppu_check(0, a);
    endtask

    task automatic swap_req_pulse();
        swap_req = 1;
        cycle();
        swap_req = 0;
        chk("pending_rise", swap_pending, 1);
    endtask

    // Call while a swap is pending; vblank is cycle T.
    task automatic vblank_swap(input bit drop, input bit latch, input bit wr_vb);
        int ws, wa;
        logic [DATA_W-1:0] wd;
        vblank_start = 1;
        if (wr_vb) begin
            ws = int'($urandom_range(0, NSEG-1));
            wa = int'($urandom_range(0, DEPTH-1));
            wd = DATA_W'($urandom);
            cpu_req = 1; cpu_we = 1; cpu_seg = 2'(ws); cpu_addr = ADDR_W'(wa); cpu_wdata = wd;
            mm[1-mfront][ws][wa] = wd;
        end
        cycle();
        vblank_start = 0; cpu_req = 0; cpu_we = 0;
        mfront = 1 - mfront;
        chk("flip_front", front_sel, 64'(mfront));
        chk("busy_rise", sync_busy, 1);
        chk("pending_drop", swap_pending, 0);
        chk("ready_low", cpu_ready, 0);
        for (int c = 2; c <= DEPTH + 2; c++) begin
            if (drop && c < DEPTH) begin
                cpu_req = 1; cpu_we = 1;
                cpu_seg = 2'($urandom_range(0, NSEG-1));
                cpu_addr = ADDR_W'($urandom_range(0, DEPTH-1));
                cpu_wdata = DATA_W'($urandom);
            end
            if (latch && c == 5) swap_req = 1;
            cycle();
            cpu_req = 0; cpu_we = 0; swap_req = 0;
            if (c <= DEPTH + 1) begin
                chk("copy_busy", sync_busy, 1);
                chk("copy_ready", cpu_ready, 0);
                chk("copy_done_low", swap_done, 0);
            end else begin
                chk("swap_done", swap_done, 1);
                chk("busy_fall", sync_busy, 0);
                chk("ready_back", cpu_ready, 1);
                chk("pending_after", swap_pending, 64'(latch));
            end
        end
        for (int s = 0; s < NSEG; s++)
            for (int a = 0; a < DEPTH; a++)
                mm[1-mfront][s][a] = mm[mfront][s][a];
        cycle();
        chk("done_pulse", swap_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_seg = '0; cpu_addr = '0; cpu_wdata = '0;
        swap_req = 0; vblank_start = 0; ppu_addr = '0;
        cycle(); cycle();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_pending", swap_pending, 0);
        chk("rst_busy", sync_busy, 0);
        chk("rst_done", swap_done, 0);
        chk("rst_front", front_sel, 0);
        chk("rst_ppu", ppu_rdata, 0);
        rst_n = 1;
        cycle();
        chk("ready_after_rst", cpu_ready, 1);

        // Fill the back bank, then swap so both banks hold known data.
        for (int s = 0; s < NSEG; s++)
            for (int a = 0; a < DEPTH; a++)
                cpu_write(s, a, DATA_W'($urandom));
        for (int i = 0; i < 8; i++)
            cpu_read(int'($urandom_range(0, NSEG-1)), int'($urandom_range(0, DEPTH-1)));
        swap_req_pulse();
        vblank_swap(0, 0, 0);
        verify_all();

        // Back-bank write is visible to the CPU at once but not to the PPU.
        cpu_write(2, 5, 16'hBEEF);
        cpu_read(2, 5);
        cycle();
        chk("rvalid_pulse", cpu_rvalid, 0);
        ppu_check(0, 5);
        cpu_read(1, 20);
        cpu_write(0, 25, 16'h1234);
        cpu_read(0, 25);

        // Swap with a write on the vblank cycle and dropped writes during the copy.
        swap_req_pulse();
        cycle(); cycle();
        chk("pending_hold", swap_pending, 1);
        vblank_swap(1, 0, 1);
        cpu_read(2, 5);
        ppu_check(0, 5);
        verify_all();

        // vblank without a request, then request and vblank together.
        vblank_start = 1;
        cycle();
        vblank_start = 0;
        chk("idle_vblank_front", front_sel, 64'(mfront));
        chk("idle_vblank_pending", swap_pending, 0);
        swap_req = 1; vblank_start = 1;
        cycle();
        swap_req = 0; vblank_start = 0;
        chk("same_cycle_front", front_sel, 64'(mfront));
        chk("same_cycle_pending", swap_pending, 1);
        cycle();
        swap_req = 1;
        cycle();
        swap_req = 0;
        chk("pending_ignore_req", swap_pending, 1);
        vblank_swap(0, 0, 0);
        verify_all();

        // Request during a copy re-arms the swap.
        swap_req_pulse();
        vblank_swap(0, 1, 0);
        vblank_swap(0, 0, 0);
        verify_all();

        // Reset in the middle of a copy; banks are equal here so the model stays exact.
        swap_req_pulse();
        vblank_start = 1;
        cycle();
        vblank_start = 0;
        repeat (7) cycle();
        chk("busy_before_rst", sync_busy, 1);
        rst_n = 0;
        #1;
        chk("arst_front", front_sel, 0);
        chk("arst_busy", sync_busy, 0);
        chk("arst_ready", cpu_ready, 0);
        chk("arst_pending", swap_pending, 0);
        chk("arst_done", swap_done, 0);
        chk("arst_rvalid", cpu_rvalid, 0);
        chk("arst_rdata", cpu_rdata, 0);
        chk("arst_ppu", ppu_rdata, 0);
        cycle();
        rst_n = 1;
        mfront = 0;
        cycle();
        chk("rel_ready", cpu_ready, 1);
        chk("rel_front", front_sel, 0);
        chk("rel_busy", sync_busy, 0);
        verify_all();

        // Random CPU/PPU traffic, then a final swap.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: cpu_write(int'($urandom_range(0, NSEG-1)), int'($urandom_range(0, 2*DEPTH-1)),
                             DATA_W'($urandom));
                1: cpu_read(int'($urandom_range(0, NSEG-1)), int'($urandom_range(0, 2*DEPTH-1)));
                default: ppu_check(1, 0);
            endcase
        end
        swap_req_pulse();
        vblank_swap(1, 0, 1);
        verify_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_dbuf.md
# vram_dbuf

Parametrised, N-segment, double-buffered VRAM with a hardware swap-and-sync controller. It is the next generation of the PPU's 4-segment dual-port double-buffered VRAM. The CPU side reads and writes the back bank of every segment through a single segment-selected port. The PPU side reads the front bank of all segments in parallel. On a CPU swap request, the banks exchange at the next vblank start, and the controller then copies the new front into the new back so the CPU resumes editing a coherent frame.

## Interface
Parameters:
- NSEG, 4: number of segments, ≥1.
- ADDR_W, 12: word-address width per segment.
- DATA_W, 16: word width per segment.
- DEPTH, 2**ADDR_W: words per segment bank, ≤2**ADDR_W.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_seg  in  $clog2(NSEG) (min 1)  target segment.
- cpu_addr  in  ADDR_W  word address in the back bank.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  access accepted this cycle when cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data from the back bank.
- swap_req  in  1  pulse: request a bank swap at the next vblank.
- vblank_start  in  1  pulse from PPU timing at the start of vblank.
- swap_pending  out  1  a swap is armed and waiting for vblank.
- sync_busy  out  1  front→back copy in progress.
- swap_done  out  1  one-cycle pulse, copy complete.
- front_sel  out  1  bank index currently shown to the PPU.
- ppu_addr  in  NSEG*ADDR_W  per-segment read addresses; segment i occupies [i*ADDR_W +: ADDR_W].
- ppu_rdata  out  NSEG*DATA_W  per-segment front-bank read data, same packing.

## Operation
- Storage: each segment has 2 banks of DEPTH×DATA_W, and each bank is true dual-port. Port A serves the PPU when the bank is front. Port B serves the CPU when the bank is back; during sync it serves the copy read when front and the copy write when back.
- Memory contents are not reset. All registers reset: front_sel=0, state IDLE, cpu_ready=0 while rst_n low and 1 from the first cycle after release, cpu_rvalid=0, cpu_rdata=0, swap_pending=0, sync_busy=0, swap_done=0, ppu_rdata=0.
- FSM states:
  - IDLE: swap_req → PENDING.
  - PENDING: vblank_start → flip front_sel, enter COPY with copy counter=0. swap_req in this state is ignored.
  - COPY: each cycle, read new-front word at counter across all segments in parallel. Write the returned word to the new-back bank at counter-1 one cycle later. After the write of address DEPTH-1 → IDLE, pulse swap_done.
- Only PENDING reacts to vblank_start. vblank_start in IDLE or COPY has no effect.
- swap_req and vblank_start in the same IDLE cycle: go to PENDING only; the swap waits for the next vblank_start.
- swap_req during COPY is latched. On COPY exit the FSM goes to PENDING instead of IDLE, and swap_done still pulses.
- cpu_ready=0 throughout COPY. Requests with cpu_ready=0 are dropped, not queued: no write, no rvalid. cpu_ready=1 in IDLE and PENDING.
- A CPU write in the vblank_start cycle lands in the old back bank, which becomes the new front. Because the copy starts the next cycle, the write also reaches the new back.
- cpu_seg ≥ NSEG or cpu_addr ≥ DEPTH: a write is discarded, and a read returns rvalid with data 0.
- Copy counter is $clog2(DEPTH+1) bits and does not wrap.

## Timing
- CPU read: request at cycle t, cpu_rvalid and cpu_rdata at t+1. CPU write is visible to a read issued at t+1.
- PPU read: ppu_addr at t, ppu_rdata at t+1, using the bank given by front_sel at t.
- Swap, with vblank_start at T in PENDING:
  - front_sel and sync_busy go high/flip at T+1.
  - swap_pending drops at T+1.
  - Copy reads run T+1..T+DEPTH; copy writes run T+2..T+DEPTH+1.
  - sync_busy and cpu_ready low for T+1..T+DEPTH+1.
  - swap_done=1 and cpu_ready=1 at T+DEPTH+2.
- swap_pending rises the cycle after swap_req in IDLE. After a latched swap_req, swap_pending rises with swap_done.
- Reset asserted mid-COPY: immediate return to reset values, copy abandoned, front_sel=0. Bank contents are left partially copied.

## Test plan
- Reset, NSEG=4, DEPTH=16: write seg2 addr5=0xBEEF, read back → rvalid at t+1 with 0xBEEF. PPU seg2 addr5 still reads the old front value.
- swap_req, then vblank_start at T → front_sel=1 at T+1. PPU seg2 addr5 reads 0xBEEF. swap_done at T+18. CPU read seg2 addr5 then returns 0xBEEF, showing the copy.
- CPU write attempts during COPY → cpu_ready=0, writes dropped. After swap_done, the back bank equals the front bank at all 4×16 addresses.
- swap_req and vblank_start in the same IDLE cycle → no flip. The next vblank_start flips. vblank_start in IDLE without a request → no flip.
- swap_req during COPY → after swap_done, swap_pending=1. The next vblank_start flips front_sel back to 0.
- rst_n low at T+8 mid-COPY → all outputs take reset values asynchronously, front_sel=0, and the FSM is back in IDLE after release.
